// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
// The mode encoding matches the single-bit 'mode' input of rr_stream_mux.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at (ptr+1) mod N
// and the first requesting channel found wins.
module rr_arbiter #(
  parameter int  N    = 16,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any_gnt
);

  logic [SELW-1:0] start;
  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [SELW-1:0] enc;
  logic [SELW:0]   sum;

  // Wrap explicitly so that a non-power-of-two N still rotates correctly.
  assign start = (ptr == SELW'(N - 1)) ? '0 : ptr + 1'b1;
  assign dbl   = {req, req} >> start;
  assign rot   = dbl[N-1:0];

  always_comb begin
    enc = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) enc = SELW'(k);
    end
  end

  // Rotate back: the encoded offset is relative to 'start'.
  assign sum     = {1'b0, start} + {1'b0, enc};
  assign gnt_idx = (sum >= (SELW+1)'(N)) ? SELW'(sum - (SELW+1)'(N)) : sum[SELW-1:0];
  assign any_gnt = |req;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign gnt[gi] = any_gnt && (gnt_idx == SELW'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output slot,
// selectable between an explicit channel select and round-robin arbitration.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  N     = 16,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_chan_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  ptr_reg;

  logic             load_en;
  logic [N-1:0]     rr_gnt;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic             man_ok;
  logic [N-1:0]     man_gnt;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             grant_any;
  logic             is_rr;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .any_gnt (rr_any)
  );

  // The extra bit keeps the range test meaningful when N is a power of two.
  assign man_ok = ({1'b0, sel} < (SELW+1)'(N)) && in_valid[sel];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_man
      assign man_gnt[gi] = man_ok && (sel == SELW'(gi));
    end
  endgenerate

  assign is_rr     = (mode == MODE_RR);
  assign grant     = is_rr ? rr_gnt : man_gnt;
  assign grant_idx = is_rr ? rr_idx : sel;
  assign grant_any = is_rr ? rr_any : man_ok;

  assign load_en  = !out_valid_reg || out_ready;
  assign in_ready = grant & {N{load_en}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= SELW'(N - 1);
    end else if (load_en) begin
      if (grant_any) begin
        out_data_reg  <= in_data[grant_idx*WIDTH +: WIDTH];
        out_chan_reg  <= grant_idx;
        out_valid_reg <= 1'b1;
        // Only accepted round-robin transfers move the fairness pointer.
        if (is_rr) ptr_reg <= grant_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;

endmodule
